ram_bank: RTL and testbench
===========================

# ram_bank

Parametrised single-clock synchronous RAM bank, the successor to the fixed 32×32 RAM behind the AXI4-Lite slave. It adds configurable width and depth, per-byte write strobes (mapped from WSTRB), out-of-range detection (mapped to SLVERR), a read-valid qualifier and a hardware init sequencer that loads a known pattern after every reset. It sits directly under the AXI4-Lite slave's read/write channel logic.

## Interface
- DATA_W, 32: data width in bits; multiple of 8, ≥ 8.
- DEPTH, 32: number of words; ≥ 2. Need not be a power of two.
- ADDR_W, 32: address port width; word addressing (address N selects word N).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- write_EN  in  1  write request, sampled every cycle.
- write_address  in  ADDR_W  word index for write.
- write_data  in  DATA_W  write data.
- write_strb  in  DATA_W/8  byte enables; bit k gates write_data[8k+7:8k].
- read_EN  in  1  read request.
- read_address  in  ADDR_W  word index for read.
- ready  out  1  high when requests are accepted (state RUN).
- read_data  out  DATA_W  read result, valid only with read_valid.
- read_valid  out  1  one-cycle pulse qualifying read_data/read_error.
- read_error  out  1  read address ≥ DEPTH; qualified by read_valid.
- write_error  out  1  one-cycle pulse: write address ≥ DEPTH.

## Operation
- FSM states: INIT, RUN. rst → INIT, init index idx = 0.
- INIT: each cycle writes mem[idx] = (2·idx) truncated to DATA_W, idx++. After writing idx = DEPTH−1, go to RUN. Requests are ignored (no write, no read_valid, no errors) while in INIT.
- RUN: write_EN with address < DEPTH updates only the bytes whose strobe bit is 1. write_strb = 0 is a legal no-op without error.
- Write with address ≥ DEPTH: memory unchanged, write_error pulses. Upper address bits are never truncated to alias into range.
- read_EN with address < DEPTH: read_data = mem[addr], read_error = 0. With address ≥ DEPTH: read_data = 0, read_error = 1.
- Same-cycle read and write to the same address: the read returns the old data (read-before-write).
- One read and one write accepted per cycle. There is no backpressure in RUN.
- rst asserted at any time, including mid-INIT or with a read in flight: it clears all pipeline valids and restarts INIT at idx 0. Memory contents are overwritten by the new INIT.

## Timing
- Reset values: ready = 0, read_valid = 0, read_error = 0, write_error = 0, read_data = 0.
- Initialisation: with rst low from cycle 0, INIT writes in cycles 0 … DEPTH−1. ready = 1 from cycle DEPTH onward.
- Read latency, macro off: 1 cycle. read_EN is sampled at edge n, and read_data/read_valid are valid after edge n, for one cycle.
- Read latency, macro on: 2 cycles.
- write_error is asserted the cycle after the offending write_EN is sampled.
- Back-to-back reads every cycle produce read_valid every cycle.

## Configuration
- RAM_BANK_OUT_REG_EN defined: adds an output register stage on read_data, read_valid and read_error, giving 2-cycle read latency for timing closure. This stage is reset by rst.
- RAM_BANK_OUT_REG_EN undefined: 1-cycle read latency and no extra stage.
- Write behaviour and write_error timing are identical in both builds.

## Structure
- Package ram_bank_pkg: state enum (INIT, RUN), default parameter values, a function computing the init pattern value for an index, and the index width localparam computed via $clog2(DEPTH).
- Sub-module ram_bank_init_seq: the INIT/RUN FSM plus the idx counter. It outputs ready, init_we, init_idx and init_data, and the top muxes these onto the write port during INIT.

## Test plan
- Release reset: ready stays low for 32 cycles, then rises. Reading addresses 0, 5 and 31 returns 0x0, 0xA and 0x3E, with read_valid one cycle later (two with the macro).
- Write 0xAABBCCDD to address 3 with strb 0b0101, then read 3: returns 0x00BB00DD (old value 0x6), i.e. bytes 0 and 2 updated.
- Write to address 32 and read address 40: write_error pulses once, read_error = 1 with read_data = 0, and a read of address 0 remains 0x0.
- Same-cycle write 0x1234 to address 7 and read address 7: the read returns 0xE. A read the next cycle returns 0x1234.
- Assert rst for one cycle mid-INIT (at idx 10) and mid-read: read_valid is cleared, ready stays low for 32 more cycles, and address 3, previously written, reads back 0x6.
- Stream reads of addresses 0–31 every cycle: 32 consecutive read_valid pulses in address order.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// Shared types, default parameters and init-pattern helper for the ram_bank block.
package ram_bank_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned IDX_W_DEF  = $clog2(DEPTH_DEF);

    // Value loaded into word idx after every reset; caller truncates to DATA_W.
    function automatic logic [63:0] init_pattern(input logic [31:0] idx);
        return {31'b0, idx, 1'b0};
    endfunction

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_bank_init_seq.sv
// INIT/RUN sequencer: walks every word index once after reset, then raises ready.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_INIT | writing init_pattern(idx) to word idx, requests ignored
//   ST_RUN  | init done, ready high, user requests accepted
module ram_bank_init_seq
    import ram_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              init_we,
    output logic [IDX_W-1:0]  init_idx,
    output logic [DATA_W-1:0] init_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign init_we   = (state_q == ST_INIT);
    assign init_idx  = idx_q;
    assign init_data = DATA_W'(init_pattern(32'(idx_q)));

endmodule

// File: rtl/ram_bank.sv
// Parametrised single-clock RAM bank with byte strobes, range errors and init sequencer.
// Optional RAM_BANK_OUT_REG_EN adds a reset output stage on the read path (2-cycle latency).
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_EN,
    input  logic [ADDR_W-1:0]   write_address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] write_strb,
    input  logic                read_EN,
    input  logic [ADDR_W-1:0]   read_address,
    output logic                ready,
    output logic [DATA_W-1:0]   read_data,
    output logic                read_valid,
    output logic                read_error,
    output logic                write_error
);

    localparam int unsigned   IDX_W  = idx_width(DEPTH);
    localparam int unsigned   STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic              seq_ready;
    logic              init_we;
    logic [IDX_W-1:0]  init_idx;
    logic [DATA_W-1:0] init_data;

    ram_bank_init_seq #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .ready     (seq_ready),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_data (init_data)
    );

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Full-width compare so out-of-range addresses never alias into the array.
    logic wr_in_range, rd_in_range;
    assign wr_in_range = ({1'b0, write_address} < DEPTH_X);
    assign rd_in_range = ({1'b0, read_address}  < DEPTH_X);

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_strb;

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = init_idx;
        mem_wdata = init_data;
        mem_strb  = '1;
        if (!seq_ready) begin
            mem_we = init_we & ~rst;
        end else begin
            mem_we    = write_EN & wr_in_range & ~rst;
            mem_idx   = write_address[IDX_W-1:0];
            mem_wdata = write_data;
            mem_strb  = write_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (mem_strb[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q,   rd_err_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              wr_err_q,   wr_err_d;

    // mem_q is read before this edge's write lands, giving read-before-write.
    always_comb begin
        rd_valid_d = seq_ready & read_EN;
        rd_err_d   = rd_valid_d & ~rd_in_range;
        rd_data_d  = '0;
        if (rd_valid_d && rd_in_range) begin
            rd_data_d = mem_q[read_address[IDX_W-1:0]];
        end
        wr_err_d = seq_ready & write_EN & ~wr_in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            wr_err_q   <= wr_err_d;
        end
    end

`ifdef RAM_BANK_OUT_REG_EN
    logic              out_valid_q;
    logic              out_err_q;
    logic [DATA_W-1:0] out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_valid_q;
            out_err_q   <= rd_err_q;
            out_data_q  <= rd_data_q;
        end
    end

    assign read_valid = out_valid_q;
    assign read_error = out_err_q;
    assign read_data  = out_data_q;
`else
    assign read_valid = rd_valid_q;
    assign read_error = rd_err_q;
    assign read_data  = rd_data_q;
`endif

    assign ready       = seq_ready;
    assign write_error = wr_err_q;

endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: driver queues expected reads, negedge monitor checks them.
module tb_ram_bank;

    logic        clk;
    logic        rst;
    logic        write_EN;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        read_EN;
    logic [31:0] read_address;
    logic        ready;
    logic [31:0] read_data;
    logic        read_valid;
    logic        read_error;
    logic        write_error;

    ram_bank dut (
        .clk           (clk),
        .rst           (rst),
        .write_EN      (write_EN),
        .write_address (write_address),
        .write_data    (write_data),
        .write_strb    (write_strb),
        .read_EN       (read_EN),
        .read_address  (read_address),
        .ready         (ready),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .read_error    (read_error),
        .write_error   (write_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   streak     = 0;
    int   max_streak = 0;
    int   wr_err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (read_valid) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read_valid actual data=0x%08h err=%0b required=no pulse",
                         read_data, read_error);
            end else begin
                e = sb_q.pop_front();
                check("read_data", read_data, e.data);
                check("read_error", 32'(read_error), 32'(e.err));
            end
            streak++;
        end else begin
            streak = 0;
        end
        if (streak > max_streak) max_streak = streak;
        if (write_error) wr_err_cnt++;
    end

    task automatic cyc(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input logic re, input logic [31:0] ra,
                       input logic [31:0] ed, input logic ee);
        @(negedge clk);
        write_EN      = we;
        write_address = wa;
        write_data    = wd;
        write_strb    = ws;
        read_EN       = re;
        read_address  = ra;
        if (re) sb_q.push_back('{data: ed, err: ee});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Holds a read request during INIT; none may be answered. Called at a negedge with rst low.
    task automatic wait_ready(input string name);
        int n;
        int early;
        n = 0;
        early = 0;
        read_EN = 1'b1;
        read_address = 32'd2;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (read_valid) early++;
        end while (!ready && n < 100);
        read_EN = 1'b0;
        check(name, 32'(n), 32'd32);
        check({name, "_no_valid"}, 32'(early), 32'd0);
    endtask

    function automatic logic [31:0] stream_exp(input int a);
        if (a == 3) return 32'h00BB00DD;
        if (a == 7) return 32'h0000_1234;
        return 32'(2 * a);
    endfunction

    initial begin
        rst = 1'b1;
        write_EN = 1'b0;
        write_address = '0;
        write_data = '0;
        write_strb = '0;
        read_EN = 1'b0;
        read_address = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_read_valid", 32'(read_valid), 32'd0);
        check("rst_read_error", 32'(read_error), 32'd0);
        check("rst_write_error", 32'(write_error), 32'd0);
        check("rst_read_data", read_data, 32'd0);

        rst = 1'b0;
        wait_ready("init_cycles");

        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd0,  32'h0,  1'b0);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd5,  32'hA,  1'b0);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd31, 32'h3E, 1'b0);
        idle(3);

        cyc(1'b1, 32'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd3, 32'h00BB00DD, 1'b0);
        cyc(1'b1, 32'd5, 32'hFFFFFFFF, 4'b0000, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd5, 32'hA, 1'b0);
        idle(3);
        check("strb0_no_error", 32'(wr_err_cnt), 32'd0);

        wr_err_cnt = 0;
        cyc(1'b1, 32'd32, 32'hDEADBEEF, 4'hF, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd40, 32'h0, 1'b1);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd0,  32'h0, 1'b0);
        idle(3);
        check("write_error_pulses", 32'(wr_err_cnt), 32'd1);

        cyc(1'b1, 32'd7, 32'h1234, 4'hF, 1'b1, 32'd7, 32'hE, 1'b0);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd7, 32'h1234, 1'b0);
        idle(3);

        max_streak = 0;
        for (int a = 0; a < 32; a++) cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'(a), stream_exp(a), 1'b0);
        idle(4);
        check("stream_streak", 32'(max_streak), 32'd32);

        // Reset coinciding with a read request: nothing may come back.
        @(negedge clk);
        rst = 1'b1;
        read_EN = 1'b1;
        read_address = 32'd5;
        @(negedge clk);
        check("rst_flush_valid", 32'(read_valid), 32'd0);
        check("rst_ready_low", 32'(ready), 32'd0);
        rst = 1'b0;
        read_EN = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midinit_ready_low", 32'(ready), 32'd0);
        wait_ready("reinit_cycles");

        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd3, 32'h6, 1'b0);
        cyc(1'b0, 0, 0, 4'h0, 1'b1, 32'd7, 32'hE, 1'b0);
        idle(4);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
